// File: rtl/ecc_job_sequencer_if.sv
// ECC engine port bundle: APB write master signals plus the engine completion/result.
// Latency: none, wires only.
// Backpressure: none; the engine is always writable and reports completion with operation_done.
//
// Ports (master = sequencer side, slave = engine side):
//   PADDR, PWDATA, PSEL, PENABLE, PWRITE : APB write transfer, driven by the master
//   operation_done, data_out, num_of_errors : engine result, driven by the slave
// The instance parameters must match the sequencer's AMBA_ADDR_WIDTH/AMBA_WORD/DATA_WIDTH.
interface ecc_job_sequencer_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  operation_done, data_out, num_of_errors
    );

    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output operation_done, data_out, num_of_errors
    );
endinterface

// File: rtl/ecc_job_sequencer.sv
// Arbitrates two ECC job requesters round-robin and programs the engine over APB.
// Latency: ack 1 cycle after grant; 6 (enc/dec) or 8 (full channel) APB cycles, then WAIT until done.
// Backpressure: requests held until ack; response held in RESP until rsp_ready.
//
// Ports: clk, rst (async active-low); req0_*/req1_* job inputs with one-cycle ack pulses;
//   eng (master modport) = APB write bus + engine result; rsp_* response channel; busy.
// Optional feature: define ECC_SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with status 01.
module ecc_job_sequencer #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ack,
    input  logic [1:0]            req0_mode,
    input  logic [1:0]            req0_width,
    input  logic [31:0]           req0_data,
    input  logic [31:0]           req0_noise,
    input  logic                  req1_valid,
    output logic                  req1_ack,
    input  logic [1:0]            req1_mode,
    input  logic [1:0]            req1_width,
    input  logic [31:0]           req1_data,
    input  logic [31:0]           req1_noise,
    ecc_job_sequencer_if.master   eng,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_errors,
    output logic [1:0]            rsp_status,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] MODE_FULL    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // Write-list index: 0 width, 1 data, 2 noise, 3 ctrl.
    localparam logic [1:0] STEP_WIDTH = 2'd0;
    localparam logic [1:0] STEP_DATA  = 2'd1;
    localparam logic [1:0] STEP_NOISE = 2'd2;
    localparam logic [1:0] STEP_CTRL  = 2'd3;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;     // requester favoured on a tie
    logic                  id_q, id_d;
    logic [1:0]            mode_q, mode_d;
    logic [1:0]            width_q, width_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           noise_q, noise_d;
    logic [1:0]            step_q, step_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rerr_q, rerr_d;
    logic [1:0]            rstat_q, rstat_d;

    logic                  grant_id;
    logic [1:0]            sel_mode;
`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            mode_q  <= 2'b0;
            width_q <= 2'b0;
            data_q  <= 32'b0;
            noise_q <= 32'b0;
            step_q  <= STEP_WIDTH;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 2'b0;
            rstat_q <= 2'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            width_q <= width_d;
            data_q  <= data_d;
            noise_q <= noise_d;
            step_q  <= step_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            rstat_q <= rstat_d;
`ifdef ECC_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        mode_d   = mode_q;
        width_d  = width_q;
        data_d   = data_q;
        noise_d  = noise_q;
        step_d   = step_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rstat_d  = rstat_q;
`ifdef ECC_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        // A lone requester always wins; on a tie the favoured one does.
        grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
        sel_mode = grant_id ? req1_mode : req0_mode;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                    mode_d  = sel_mode;
                    width_d = grant_id ? req1_width : req0_width;
                    data_d  = grant_id ? req1_data  : req0_data;
                    noise_d = grant_id ? req1_noise : req0_noise;
                    step_d  = STEP_WIDTH;
                    if (sel_mode == MODE_ILLEGAL) begin
                        // Answered without touching the engine.
                        rdata_d = '0;
                        rerr_d  = 2'b0;
                        rstat_d = 2'b10;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                state_d = SETUP;
                case (step_q)
                    STEP_WIDTH: step_d = STEP_DATA;
                    STEP_DATA:  step_d = (mode_q == MODE_FULL) ? STEP_NOISE : STEP_CTRL;
                    STEP_NOISE: step_d = STEP_CTRL;
                    default: begin
                        state_d = WAIT;
`ifdef ECC_SEQ_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                endcase
            end
            WAIT: begin
                if (eng.operation_done) begin
                    rdata_d = eng.data_out;
                    rerr_d  = eng.num_of_errors;
                    rstat_d = 2'b00;
                    state_d = RESP;
                end
`ifdef ECC_SEQ_TIMEOUT_EN
                // tmo_q counts completed WAIT cycles; this is WAIT cycle tmo_q+1.
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    rerr_d  = 2'b0;
                    rstat_d = 2'b01;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic        in_apb;
    logic [3:0]  addr4;
    logic [31:0] wdata;

    always_comb begin
        in_apb = (state_q == SETUP) || (state_q == ACCESS);
        case (step_q)
            STEP_WIDTH: begin addr4 = 4'h8; wdata = {30'b0, width_q}; end
            STEP_DATA:  begin addr4 = 4'h4; wdata = data_q;           end
            STEP_NOISE: begin addr4 = 4'hC; wdata = noise_q;          end
            default:    begin addr4 = 4'h0; wdata = {30'b0, mode_q};  end
        endcase
    end

    // Decoded straight from state so an async reset drops PSEL/PENABLE at once.
    assign eng.PSEL    = in_apb;
    assign eng.PWRITE  = in_apb;
    assign eng.PENABLE = (state_q == ACCESS);
    assign eng.PADDR   = in_apb ? AMBA_ADDR_WIDTH'(addr4) : '0;
    assign eng.PWDATA  = in_apb ? AMBA_WORD'(wdata) : '0;

    assign req0_ack   = ack0_q;
    assign req1_ack   = ack1_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = rdata_q;
    assign rsp_errors = rerr_q;
    assign rsp_status = rstat_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Randomised bench for ecc_job_sequencer with an engine model and a job-level reference.
// Latency: n/a.
// Backpressure: rsp_ready held low for random spells to check response stability.
module tb_ecc_job_sequencer;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ack, req1_ack;
    logic [1:0]  req0_mode, req0_width, req1_mode, req1_width;
    logic [31:0] req0_data, req0_noise, req1_data, req1_noise;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors, rsp_status;

    ecc_job_sequencer_if bus();

    ecc_job_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ack(req0_ack), .req0_mode(req0_mode),
        .req0_width(req0_width), .req0_data(req0_data), .req0_noise(req0_noise),
        .req1_valid(req1_valid), .req1_ack(req1_ack), .req1_mode(req1_mode),
        .req1_width(req1_width), .req1_data(req1_data), .req1_noise(req1_noise),
        .eng(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_errors(rsp_errors), .rsp_status(rsp_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Job-level reference state.
    int          last_grant = -1;
    logic [1:0]  pend = 2'b00;
    logic [1:0]  j_mode [2];
    logic [1:0]  j_width [2];
    logic [31:0] j_data [2];
    logic [31:0] j_noise [2];

    typedef struct packed {
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    // Bus monitor state.
    wr_t         wr_q[$];
    int          apb_cyc = 0, proto_err = 0, cyc = 0, ctrl_cyc = 0, rsp_cyc = 0;
    bit          prev_setup = 0, prev_rsp = 0;
    logic [19:0] s_addr;
    logic [31:0] s_data;

    // Engine model controls.
    logic [31:0] eng_data = 0;
    logic [1:0]  eng_err = 0;
    int          eng_delay = 1, eng_cnt = 0;
    bit          eng_never = 0, eng_spur_en = 0, eng_spur = 0;

    always @(negedge clk) begin
        cyc++;
        if (rsp_valid && !prev_rsp) rsp_cyc = cyc;
        prev_rsp = rsp_valid;
        if (bus.PSEL) begin
            apb_cyc++;
            if (!bus.PWRITE) proto_err++;
            if ((bus.PADDR & 20'hFFFF3) != 20'h0) proto_err++;
            if (!bus.PENABLE) begin
                if (prev_setup) proto_err++;
                s_addr = bus.PADDR;
                s_data = bus.PWDATA;
                prev_setup = 1;
                if (eng_spur_en) begin
                    eng_spur = 1;
                    eng_spur_en = 0;
                end
            end else begin
                if (!prev_setup || bus.PADDR != s_addr || bus.PWDATA != s_data) proto_err++;
                prev_setup = 0;
                wr_q.push_back('{addr: bus.PADDR, data: bus.PWDATA});
                if (bus.PADDR == 20'h0) begin
                    ctrl_cyc = cyc;
                    if (!eng_never) eng_cnt = eng_delay;
                end
            end
        end else begin
            if (bus.PENABLE || bus.PWRITE) proto_err++;
            prev_setup = 0;
        end
    end

    // Engine: completes eng_delay cycles into WAIT; an armed spurious pulse carries junk.
    initial begin
        bus.operation_done = 0;
        bus.data_out = 0;
        bus.num_of_errors = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.operation_done = 0;
            if (eng_spur) begin
                bus.operation_done = 1;
                bus.data_out = ~eng_data;
                bus.num_of_errors = ~eng_err;
                eng_spur = 0;
            end else if (eng_cnt == 1) begin
                bus.operation_done = 1;
                bus.data_out = eng_data;
                bus.num_of_errors = eng_err;
                eng_cnt = 0;
            end else if (eng_cnt > 1) begin
                eng_cnt--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int winner();
        if (pend == 2'b11) return (last_grant == 0) ? 1 : 0;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic post(input int id, input logic [1:0] m, input logic [1:0] w,
                        input logic [31:0] d, input logic [31:0] n);
        j_mode[id] = m; j_width[id] = w; j_data[id] = d; j_noise[id] = n;
        pend[id] = 1'b1;
        if (id == 0) begin
            req0_mode = m; req0_width = w; req0_data = d; req0_noise = n; req0_valid = 1;
        end else begin
            req1_mode = m; req1_width = w; req1_data = d; req1_noise = n; req1_valid = 1;
        end
    endtask

    task automatic drop(input int id);
        if (id == 0) req0_valid = 0;
        else req1_valid = 0;
    endtask

    task automatic model_reset();
        pend = 2'b00;
        last_grant = -1;
        eng_cnt = 0;
        eng_never = 0;
        eng_spur_en = 0;
        eng_spur = 0;
    endtask

    // Runs one granted job end to end against the reference.
    task automatic serve(input string tag, input bit exp_timeout, input bit spur, input int err_sel);
        int          exp_id, got, w, lat, exp_wait, hold;
        bit          ack_seen, early;
        wr_t         exp_q[$];
        logic [1:0]  m, es, ee;
        logic [31:0] ed;
        exp_id = winner();
        m = j_mode[exp_id];
        wr_q.delete();
        apb_cyc = 0; proto_err = 0; prev_setup = 0;
        eng_data = $urandom;
        eng_err = (err_sel < 0) ? 2'($urandom_range(0, 3)) : 2'(err_sel);
        eng_delay = $urandom_range(1, 6);
        eng_never = exp_timeout;
        eng_spur_en = spur;
        eng_cnt = 0;
        if (m != 2'b11) begin
            exp_q.push_back('{addr: 20'h8, data: {30'b0, j_width[exp_id]}});
            exp_q.push_back('{addr: 20'h4, data: j_data[exp_id]});
            if (m == 2'b10) exp_q.push_back('{addr: 20'hC, data: j_noise[exp_id]});
            exp_q.push_back('{addr: 20'h0, data: {30'b0, m}});
        end
        es = (m == 2'b11) ? 2'b10 : (exp_timeout ? 2'b01 : 2'b00);
        ed = (es == 2'b00) ? eng_data : 32'h0;
        ee = (es == 2'b00) ? eng_err : 2'b00;
        exp_wait = exp_timeout ? TMO : eng_delay;

        ack_seen = 0;
        for (int i = 0; i < 20 && !ack_seen; i++) begin
            tick();
            if (req0_ack || req1_ack) ack_seen = 1;
        end
        vectors++;
        if (!ack_seen) begin
            miscompares++;
            $display("FAIL %s ack_wait: no ack in 20 cycles, required ack%0d", tag, exp_id);
            return;
        end
        got = req1_ack ? 1 : 0;
        vectors++;
        if ((req0_ack && req1_ack) || got != exp_id) begin
            miscompares++;
            $display("FAIL %s grant: ack0=%0b ack1=%0b, required id %0d", tag, req0_ack, req1_ack, exp_id);
        end
        last_grant = exp_id;
        pend[exp_id] = 1'b0;
        early = rsp_valid;

        @(posedge clk); #1;
        drop(exp_id);
        tick();
        vectors++;
        if (req0_ack !== 1'b0 || req1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack_pulse: ack0=%0b ack1=%0b one cycle later, required 0 0", tag, req0_ack, req1_ack);
        end
        w = 1;
        while (!rsp_valid && w < 200) begin
            tick();
            w++;
        end
        lat = early ? 0 : w;
        vectors++;
        if (!rsp_valid) begin
            miscompares++;
            $display("FAIL %s rsp_wait: rsp_valid=0 after 200 cycles, required 1", tag);
            return;
        end

        vectors++;
        if (wr_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count: %0d writes, required %0d", tag, wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s write%0d: got %h, required addr %h data %h", tag, i,
                         (i < wr_q.size()) ? wr_q[i] : '0, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (apb_cyc != 2 * exp_q.size() || proto_err != 0) begin
            miscompares++;
            $display("FAIL %s apb_timing: %0d PSEL cycles %0d protocol errors, required %0d and 0",
                     tag, apb_cyc, proto_err, 2 * exp_q.size());
        end
        if (m == 2'b11) begin
            vectors++;
            if (lat > 2) begin
                miscompares++;
                $display("FAIL %s illegal_latency: %0d cycles after ack, required <= 2", tag, lat);
            end
        end else begin
            vectors++;
            if (rsp_cyc - ctrl_cyc - 1 != exp_wait) begin
                miscompares++;
                $display("FAIL %s wait_cycles: %0d, required %0d", tag, rsp_cyc - ctrl_cyc - 1, exp_wait);
            end
        end

        hold = $urandom_range(0, 2);
        for (int h = 0; h <= hold; h++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(exp_id) || rsp_status !== es ||
                rsp_data !== ed || rsp_errors !== ee || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s response: valid=%0b id=%0d status=%b data=%h err=%b busy=%0b, required 1 %0d %b %h %b 1",
                         tag, rsp_valid, rsp_id, rsp_status, rsp_data, rsp_errors, busy, exp_id, es, ed, ee);
            end
            if (h < hold) tick();
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: rsp_valid=%0b busy=%0b after handshake, required 0 0", tag, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_mode = 0; req0_width = 0; req0_data = 0; req0_noise = 0;
        req1_mode = 0; req1_width = 0; req1_data = 0; req1_noise = 0;
        repeat (3) tick();
        vectors++;
        if (req0_ack !== 1'b0 || req1_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ack0=%0b ack1=%0b busy=%0b, required 0 0 0", req0_ack, req1_ack, busy);
        end
        vectors++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0 ||
            bus.PADDR !== 20'h0 || bus.PWDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_apb: psel=%0b pen=%0b pwr=%0b addr=%h wdata=%h, required all 0",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'h0 ||
            rsp_errors !== 2'b0 || rsp_status !== 2'b0) begin
            miscompares++;
            $display("FAIL reset_rsp: valid=%0b id=%0b data=%h err=%b status=%b, required all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_errors, rsp_status);
        end
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        tick();
    endtask

    task automatic test_encode();
        post(0, 2'b00, 2'b00, 32'h5, 32'h0);
        serve("encode", 0, 0, -1);
    endtask

    task automatic test_full_channel();
        post(1, 2'b10, 2'($urandom_range(0, 2)), $urandom, 32'h4);
        serve("full_channel", 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            post(0, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), $urandom, $urandom);
            post(1, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), $urandom, $urandom);
            serve("b2b_first", 0, 0, -1);
            serve("b2b_second", 0, 0, -1);
        end
    endtask

    task automatic test_illegal();
        post($urandom_range(0, 1), 2'b11, 2'($urandom_range(0, 2)), $urandom, $urandom);
        serve("illegal", 0, 0, -1);
    endtask

    task automatic test_spurious_done();
        post(0, 2'b01, 2'b10, $urandom, $urandom);
        serve("spurious_done", 0, 1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int sel = $urandom_range(0, 2);
            for (int id = 0; id < 2; id++) begin
                if (sel == 2 || sel == id) begin
                    logic [1:0] m = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                    post(id, m, 2'($urandom_range(0, 2)), $urandom, $urandom);
                end
            end
            serve("random", 0, $urandom_range(0, 3) == 0, -1);
            if (pend != 2'b00) serve("random_pending", 0, 0, -1);
        end
    endtask

    task automatic test_timeout();
`ifdef ECC_SEQ_TIMEOUT_EN
        post(1, 2'b00, 2'b01, $urandom, $urandom);
        serve("timeout", 1, 0, -1);
`else
        int  highs = 0;
        bit  ack_seen = 0;
        post(1, 2'b00, 2'b01, $urandom, $urandom);
        eng_never = 1;
        eng_cnt = 0;
        for (int i = 0; i < 20 && !ack_seen; i++) begin
            tick();
            if (req1_ack) ack_seen = 1;
        end
        @(posedge clk); #1;
        drop(1);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rsp_valid) highs++;
        end
        vectors++;
        if (!ack_seen || highs != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout: ack=%0b rsp_valid cycles=%0d busy=%0b, required 1 0 1", ack_seen, highs, busy);
        end
        rst = 0;
        tick();
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        tick();
`endif
    endtask

    task automatic test_reset_mid_job();
        bit found = 0;
        int stray = 0;
        post(0, 2'b10, 2'b01, $urandom, $urandom);
        for (int i = 0; i < 20 && !req0_ack; i++) tick();
        @(posedge clk); #1;
        drop(0);
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.PSEL && bus.PENABLE && bus.PADDR == 20'h4) found = 1;
        end
        rst = 0;
        #1;
        vectors++;
        if (!found || bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_job: found=%0b psel=%0b pen=%0b busy=%0b, required 1 0 0 0",
                     found, bus.PSEL, bus.PENABLE, busy);
        end
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid || req0_ack || req1_ack || busy) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL reset_discard: %0d active cycles after reset, required 0", stray);
        end
        post(0, 2'b00, 2'b10, $urandom, $urandom);
        serve("after_reset", 0, 0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_encode();
        test_full_channel();
        test_back_to_back();
        test_illegal();
        test_spurious_done();
        test_random();
        test_timeout();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
